full_adder: RTL and testbench
=============================

# full_adder

One-bit full adder with a combinational sum/carry path and an optional registered copy of the result for pipelined datapaths. It is the leaf arithmetic cell used by ripple-carry adders and bit-serial units. The combinational outputs work with no clock activity. A clocked capture stage adds a valid flag and optional statistics counters.

## Interface
Parameters:
- CNT_W, 16, width of the statistics counters; legal range 4..32.

Ports:
- clk  input  1  single clock; all registers update on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- a  input  1  addend bit.
- b  input  1  addend bit.
- c0  input  1  carry-in.
- in_valid  input  1  capture strobe for the registered path. When left unconnected or not 1, no capture occurs.
- s  output  1  combinational sum, a^b^c0.
- c  output  1  combinational carry-out, majority(a,b,c0).
- s_q  output  1  registered sum.
- c_q  output  1  registered carry-out.
- out_valid  output  1  s_q/c_q hold a fresh capture from the previous cycle.
- op_cnt  output  CNT_W  number of captures; present only with FULL_ADDER_STATS_EN.
- carry_cnt  output  CNT_W  number of captures with carry-out 1; present only with FULL_ADDER_STATS_EN.

## Operation
- The combinational path is s = a^b^c0 and c = (a&b)|(c0&(a^b)). In arithmetic terms, {c,s} = a + b + c0, 2 bits wide.
- s and c depend only on a, b and c0. They are independent of clk, rst_n and in_valid.
- If any input is X or Z, s and c are allowed to be X. No other X handling applies.
- Registered path:
  - On a rising edge with rst_n=1 and in_valid=1, s_q<=s and c_q<=c, and out_valid<=1.
  - On a rising edge with rst_n=1 and in_valid!=1, s_q and c_q hold their values and out_valid<=0.
- Reset: on a rising edge with rst_n=0, s_q=0, c_q=0, out_valid=0, and both counters go to 0.
- Reset has priority over in_valid on the same edge.
- The combinational outputs are unaffected by reset.

## Timing
- Combinational path: zero cycles; outputs settle within the same delta or cell delay.
- Registered path: 1-cycle latency. Data presented with in_valid at edge N appears on s_q/c_q with out_valid=1 after edge N.
- out_valid is a single-cycle pulse per capture; it stays high for back-to-back in_valid cycles.
- There is no backpressure; every valid beat is accepted.
- Reset asserted mid-stream discards the pending result. The first valid output after reset release needs a new capture.

## Configuration
- Macro: FULL_ADDER_STATS_EN.
- When defined, the op_cnt and carry_cnt ports and registers exist:
  - op_cnt increments on each capture.
  - carry_cnt increments on each capture where c=1.
  - Both counters saturate at all-ones; they do not wrap.
- When undefined, neither port nor register exists, and the remaining behaviour is identical.

## Structure
- Package full_adder_pkg holds:
  - the CNT_W default constant;
  - typedef fa_res_t, a 2-bit packed struct {carry, sum};
  - the function fa_eval(a,b,c0) returning fa_res_t, used by both RTL and bench.
- One sub-module, half_adder (x, y -> sum x^y, carry x&y).
- full_adder instantiates two half_adder cells plus an OR for the carry.

## Test plan
- a=0, b=1, c0=1 with no clock toggling, check after 100 ns -> s=0, c=1.
- All 8 input combinations applied combinationally -> {c,s} equals a+b+c0 each time (e.g. 1,1,1 -> c=1, s=1; 0,0,0 -> c=0, s=0).
- rst_n=0 for 2 edges, then rst_n=1 with in_valid=1 and a=1, b=1, c0=0 -> after 1 edge s_q=0, c_q=1, out_valid=1; next edge with in_valid=0 -> out_valid=0, s_q/c_q held.
- Capture a=1, b=0, c0=0, then assert rst_n=0 together with in_valid=1 on the next edge -> s_q=0, c_q=0, out_valid=0.
- FULL_ADDER_STATS_EN defined, CNT_W=4, 20 captures of a=1, b=1, c0=1 -> op_cnt=15 and carry_cnt=15 (saturated); reset -> both 0.

Source files
------------

// File: rtl/full_adder_pkg.sv
// Shared types and the reference evaluation for the one-bit full adder.
// Pure declarations: no latency, no flow control.
package full_adder_pkg;

  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic carry;
    logic sum;
  } fa_res_t;

  function automatic fa_res_t fa_eval(input logic a, input logic b, input logic c0);
    fa_res_t r;
    r.sum   = a ^ b ^ c0;
    r.carry = (a & b) | (c0 & (a ^ b));
    return r;
  endfunction

endpackage

// File: rtl/half_adder.sv
// Half adder leaf: sum = x^y, carry = x&y.
// Combinational, zero latency; no flow control.
module half_adder (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic carry
);

  assign sum   = x ^ y;
  assign carry = x & y;

endmodule

// File: rtl/full_adder.sv
// One-bit full adder with a registered copy; FULL_ADDER_STATS_EN adds saturating capture counters.
// Combinational s/c: zero latency; s_q/c_q/out_valid: one cycle after an in_valid edge.
// No backpressure: every in_valid beat is captured.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c0,
  input  logic             in_valid,
  output logic             s,
  output logic             c,
`ifdef FULL_ADDER_STATS_EN
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] carry_cnt,
`endif
  output logic             s_q,
  output logic             c_q,
  output logic             out_valid
);

  if (CNT_W < 4 || CNT_W > 32) begin : g_bad_cnt_w
    $error("full_adder: CNT_W out of range 4..32");
  end

  logic    p_sum;
  logic    g_ab;
  logic    g_pc;
  fa_res_t res_q;

  half_adder u_ha_ab (.x(a),     .y(b),  .sum(p_sum), .carry(g_ab));
  half_adder u_ha_pc (.x(p_sum), .y(c0), .sum(s),     .carry(g_pc));

  // Both half-adder carries can never be 1 together, so OR equals the majority.
  assign c = g_ab | g_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q     <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      res_q     <= '{carry: c, sum: s};
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign s_q = res_q.sum;
  assign c_q = res_q.carry;

`ifdef FULL_ADDER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_cnt    <= '0;
      carry_cnt <= '0;
    end else if (in_valid) begin
      if (op_cnt != {CNT_W{1'b1}}) op_cnt <= op_cnt + CNT_W'(1);
      if (c && carry_cnt != {CNT_W{1'b1}}) carry_cnt <= carry_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: combinational truth table, registered path, reset priority.
// Counter saturation is exercised when FULL_ADDER_STATS_EN is defined.
module tb_full_adder;
  import full_adder_pkg::*;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0, b = 1'b0, c0 = 1'b0, in_valid = 1'b0;
  logic s, c, s_q, c_q, out_valid;
`ifdef FULL_ADDER_STATS_EN
  logic [CW-1:0] op_cnt, carry_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 if (clk_en) clk = ~clk;

  full_adder #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c0(c0), .in_valid(in_valid),
    .s(s), .c(c),
`ifdef FULL_ADDER_STATS_EN
    .op_cnt(op_cnt), .carry_cnt(carry_cnt),
`endif
    .s_q(s_q), .c_q(c_q), .out_valid(out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic va, input logic vb, input logic vc);
    a = va; b = vb; c0 = vc;
  endtask

  // {a,b,c0} -> hand-computed {c,s}
  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    // Combinational path with the clock stopped
    drive(1'b0, 1'b1, 1'b1);
    #100;
    chk("noclk_s", 32'(s), 32'd0);
    chk("noclk_c", 32'(c), 32'd1);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      fa_res_t    r;
      v = 3'(i);
      drive(v[2], v[1], v[0]);
      #1;
      chk($sformatf("tt%0d", i), 32'({c, s}), 32'(tt[i]));
      r = fa_eval(v[2], v[1], v[0]);
      chk($sformatf("fa_eval%0d", i), 32'({r.carry, r.sum}), 32'(tt[i]));
    end

    // Reset and in_valid do not touch the combinational outputs
    drive(1'b1, 1'b1, 1'b1);
    rst_n = 1'b0; in_valid = 1'b1;
    #1;
    chk("indep_111", 32'({c, s}), 32'd3);
    in_valid = 1'b0;

    // Registered path
    clk_en = 1'b1;
    tick();
    tick();
    chk("rst_sq", 32'(s_q), 32'd0);
    chk("rst_cq", 32'(c_q), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);

    rst_n = 1'b1; in_valid = 1'b1; drive(1'b1, 1'b1, 1'b0);
    tick();
    chk("cap110", 32'({c_q, s_q, out_valid}), 32'b101);

    in_valid = 1'b0; drive(1'b0, 1'b0, 1'b1);
    tick();
    chk("hold", 32'({c_q, s_q, out_valid}), 32'b100);

    in_valid = 1'b1; drive(1'b1, 1'b0, 1'b0);
    tick();
    chk("cap100", 32'({c_q, s_q, out_valid}), 32'b011);

    rst_n = 1'b0; in_valid = 1'b1; drive(1'b1, 1'b1, 1'b1);
    tick();
    chk("rst_prio", 32'({c_q, s_q, out_valid}), 32'b000);

    // After release, no output until a new capture
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("post_rst_idle", 32'({c_q, s_q, out_valid}), 32'b000);

    // Back-to-back captures keep out_valid high and track data
    in_valid = 1'b1; drive(1'b1, 1'b1, 1'b1);
    tick();
    chk("b2b_111", 32'({c_q, s_q, out_valid}), 32'b111);
    drive(0, 0, 1);
    tick();
    chk("b2b_001", 32'({c_q, s_q, out_valid}), 32'b011);
    drive(0, 1, 1);
    tick();
    chk("b2b_011", 32'({c_q, s_q, out_valid}), 32'b101);
    in_valid = 1'b0;
    tick();
    chk("b2b_end", 32'({c_q, s_q, out_valid}), 32'b100);

`ifdef FULL_ADDER_STATS_EN
    rst_n = 1'b0;
    tick();
    chk("cnt_rst_op", 32'(op_cnt), 32'd0);
    chk("cnt_rst_cy", 32'(carry_cnt), 32'd0);
    rst_n = 1'b1; in_valid = 1'b1; drive(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk("cnt_nocarry_op", 32'(op_cnt), 32'd2);
    chk("cnt_nocarry_cy", 32'(carry_cnt), 32'd0);
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("cnt_mid_op", 32'(op_cnt), 32'd7);
    chk("cnt_mid_cy", 32'(carry_cnt), 32'd5);
    for (int i = 0; i < 15; i++) tick();
    chk("cnt_sat_op", 32'(op_cnt), 32'd15);
    chk("cnt_sat_cy", 32'(carry_cnt), 32'd15);
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    chk("cnt_rst2_op", 32'(op_cnt), 32'd0);
    chk("cnt_rst2_cy", 32'(carry_cnt), 32'd0);
    rst_n = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
